// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NUM_REQ byte streams.
// Grants change only at packet boundaries; each byte is handed to the UART and tracked to completion.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int STALL_MAX  = 1024,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       pkt_done,
    output logic                       err_abort
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(STALL_MAX);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, pick;
    logic          found;
    int            cand;
    logic          last_q;
    logic [SW-1:0] stall_cnt;
    logic [GW-1:0] gap_cnt;
    logic          fetch_ok, stall_hit, gap_done;
    logic [7:0]    req_byte;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            cand = (cand >= NUM_REQ) ? cand - NUM_REQ : cand;
            if (!found && req_valid[cand[IW-1:0]]) begin
                pick  = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

    assign fetch_ok  = req_valid[grant_id];
    assign req_byte  = req_data[{grant_id, 3'b000} +: 8];
    assign stall_hit = (state == FETCH) && !fetch_ok && (stall_cnt == SW'(STALL_MAX - 1));
    assign gap_done  = (GAP_CYCLES <= 1) || (gap_cnt == GW'(GAP_CYCLES - 1));

    always_comb begin
        state_nx  = state;
        trmt      = state == SEND;
        busy      = state != IDLE;
        req_ready = (state == FETCH) ? NUM_REQ'(1) << grant_id : '0;
        case (state)
            IDLE:      state_nx = |req_valid ? FETCH : IDLE;
            FETCH:     state_nx = fetch_ok ? SEND : stall_hit ? GAP : FETCH;
            SEND:      state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = tx_done ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: state_nx = !tx_done ? WAIT_DONE : last_q ? GAP : FETCH;
            GAP:       state_nx = gap_done ? IDLE : GAP;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            tx_data   <= 8'h00;
            last_q    <= 1'b0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            pkt_done  <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            state     <= state_nx;
            pkt_done  <= (state == WAIT_DONE) && tx_done && last_q;
            err_abort <= stall_hit;
            if (state == IDLE && |req_valid) begin
                grant_id <= pick;
                rr_ptr   <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            end
            if (state == FETCH && fetch_ok) begin
                tx_data <= req_byte;
                last_q  <= req_last[grant_id];
            end
            stall_cnt <= (state == FETCH && !fetch_ok && !stall_hit) ? stall_cnt + 1'b1 : '0;
            gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench checking the scheduler against per-requester byte streams,
// a round-robin grant model and the packet/gap/stall timing rules.
module tb_uart_tx_sched;
    localparam int N = 4, SM = 16, GC = 5, DEPTH = 512, INF = 1 << 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           trmt, tx_done, busy, pkt_done, err_abort;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .STALL_MAX(SM), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done),
        .err_abort(err_abort)
    );

    logic [8:0]   mem [N][DEPTH];
    int           head [N], tail [N], sidx [N], stop_at [N], srun [N];
    int           glog [256];
    int           total = 0, bad = 0;
    int           mptr = 0, ntr = 0, npd = 0, nab = 0, nacc = 0, gn = 0;
    int           stall = 0, gap_t = -1, pd_t = -1, last_gap = 0, ucnt = 0, mg = 0, me = 0;
    logic         pend_last = 1'b0, pbusy = 1'b0, ptrmt = 1'b0, rnd_en = 1'b0;
    logic [N-1:0] pvalid = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_pkt(input int i, input int p);
        int q = p;
        while (q < DEPTH - 1 && !mem[i][q][8]) q++;
        return q + 1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) if (v[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    function automatic logic quiet();
        logic q = !busy && tx_done;
        for (int i = 0; i < N; i++) q &= (head[i] == tail[i]) && (sidx[i] == tail[i]);
        return q;
    endfunction

    task automatic push_byte(input int i, input logic [7:0] d, input logic l);
        mem[i][tail[i]] = {l, d};
        tail[i]++;
    endtask

    task automatic push(input int i, input int len);
        for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
    endtask

    // One clock: requesters pop accepted bytes and present the next, UART model runs its frame.
    task automatic step();
        logic [N-1:0] acc;
        logic tr, ab;
        int g;
        @(negedge clk);
        acc = req_valid & req_ready;
        tr  = trmt;
        ab  = err_abort;
        g   = int'(grant_id);
        @(posedge clk);
        #1;
        if (tr) begin
            tx_done = 1'b0;
            ucnt = $urandom_range(5, 2);
        end else if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) tx_done = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            logic avail, go;
            if (acc[i]) head[i]++;
            if (ab && i == g) begin
                head[i] = next_pkt(i, head[i]);
                stop_at[i] = INF;
            end
            if (!req_valid[i] || acc[i]) begin
                avail = head[i] < tail[i] && head[i] < stop_at[i];
                go = avail && (!rnd_en || srun[i] >= 3 || $urandom_range(3) != 0);
                srun[i] = (avail && !go) ? srun[i] + 1 : 0;
                req_valid[i] = go;
            end
            req_data[8*i +: 8] = mem[i][head[i]][7:0];
            req_last[i] = mem[i][head[i]][8];
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < 3000 && !quiet()) begin
            step();
            n++;
        end
        check(tag, n < 3000, 1);
        step();
    endtask

    // Reference model: round-robin grant order, stream order of bytes, packet and gap timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            mptr = 0;
            pend_last = 1'b0;
            pbusy = 1'b0;
            ptrmt = 1'b0;
            pvalid = '0;
            stall = 0;
            gap_t = -1;
            pd_t = -1;
            for (int i = 0; i < N; i++) sidx[i] = head[i];
        end else begin
            mg = int'(grant_id);
            if (gap_t >= 0) gap_t++;
            if (pd_t >= 0) pd_t++;
            if (busy && !pbusy) begin
                me = rr_pick(pvalid, mptr);
                check("grant", grant_id, me);
                mptr = (me + 1) % N;
                if (gn < 256) glog[gn] = mg;
                gn++;
                stall = 0;
            end
            check("ready_sel", req_ready == '0 || req_ready == (N'(1) << grant_id), 1);
            if (|(req_valid & req_ready)) begin
                nacc++;
                stall = 0;
            end else if (req_ready[mg] && !req_valid[mg]) stall++;
            if (trmt) begin
                check("trmt_width", ptrmt, 0);
                check("trmt_idle", tx_done, 1);
                check("tx_data", tx_data, mem[mg][sidx[mg]][7:0]);
                pend_last = mem[mg][sidx[mg]][8];
                sidx[mg]++;
                ntr++;
                if (pd_t >= 0) begin
                    last_gap = pd_t;
                    check("pkt_spacing", pd_t >= GC + 2, 1);
                    pd_t = -1;
                end
            end
            if (pkt_done) begin
                check("pkt_done_last", pend_last, 1);
                pend_last = 1'b0;
                npd++;
                gap_t = 0;
                pd_t = 0;
            end
            if (err_abort) begin
                check("stall_len", stall, SM);
                sidx[mg] = next_pkt(mg, sidx[mg]);
                nab++;
                gap_t = 0;
                stall = 0;
            end
            if (pbusy && !busy) begin
                check("gap_len", gap_t, GC);
                check("pkt_closed", pend_last, 0);
                gap_t = -1;
            end
            pbusy = busy;
            ptrmt = trmt;
            pvalid = req_valid;
        end
    end

    initial begin
        int g0, n0, t0, a0, s0, n;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            sidx[i] = 0;
            srun[i] = 0;
            stop_at[i] = INF;
            for (int p = 0; p < DEPTH; p++) mem[i][p] = '0;
        end
        repeat (3) step();
        check("rst_trmt", trmt, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_pktdone", pkt_done, 0);
        check("rst_abort", err_abort, 0);
        rst_n = 1'b1;
        // all four requesters at once, twice: order 0,1,2,3 each round
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push(i, 1);
            g0 = gn;
            wait_idle("rr_timeout");
            for (int k = 0; k < N; k++) check("rr_order", glog[g0 + k], k);
        end
        n0 = npd;
        t0 = ntr;
        push_byte(0, 8'hA5, 1'b0);
        push_byte(0, 8'h5A, 1'b0);
        push_byte(0, 8'hFF, 1'b1);
        wait_idle("t1_timeout");
        check("t1_trmt", ntr - t0, 3);
        check("t1_pkt", npd - n0, 1);
        // req2 mid-packet while req1 (and req3 in round 1) raise valid
        for (int r = 0; r < 2; r++) begin
            s0 = tail[2];
            push(2, 3);
            g0 = gn;
            n = 0;
            while (sidx[2] == s0 && n < 200) begin
                step();
                n++;
            end
            push(1, 1);
            if (r == 1) push(3, 1);
            wait_idle("t3_timeout");
            check("t3_first", glog[g0], 2);
            check("t3_next", glog[g0 + 1], (r == 1) ? 3 : 1);
            if (r == 1) check("t3_wrap", glog[g0 + 2], 1);
        end
        a0 = nab;
        t0 = ntr;
        n0 = npd;
        stop_at[1] = tail[1] + 1;
        push(1, 3);
        wait_idle("t4_timeout");
        check("t4_abort", nab - a0, 1);
        check("t4_trmt", ntr - t0, 1);
        check("t4_pkt", npd - n0, 0);
        n0 = npd;
        push(0, 2);
        push(0, 2);
        wait_idle("t5_timeout");
        check("t5_pkt", npd - n0, 2);
        check("t5_gap", last_gap, GC + 2);
        // reset while the UART frame is in flight
        push(3, 2);
        n = 0;
        while (tx_done && n < 200) begin
            step();
            n++;
        end
        step();
        check("t6_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_trmt", trmt, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", req_ready, 0);
        check("t6_grant", grant_id, 0);
        for (int i = 0; i < N; i++) begin
            head[i] = tail[i];
            stop_at[i] = INF;
            srun[i] = 0;
        end
        req_valid = '0;
        tx_done = 1'b1;
        ucnt = 0;
        repeat (2) step();
        rst_n = 1'b1;
        n0 = npd;
        g0 = gn;
        push(2, 2);
        wait_idle("t6_timeout");
        check("t6_regrant", glog[g0], 2);
        check("t6_pkt", npd - n0, 1);
        rnd_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            push($urandom_range(N - 1), $urandom_range(4, 1));
            if ($urandom_range(1) == 1) push($urandom_range(N - 1), $urandom_range(3, 1));
            repeat ($urandom_range(30)) step();
        end
        wait_idle("rand_timeout");
        check("bytes_sent", ntr, nacc);
        check("abort_total", nab, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
